// File: rtl/mul_bus_master.sv
// Bus initiator for the 4-operand arithmetic register slave: writes A..D and CTRL, polls STATUS, reads RESULT.
// Optional poll limit enabled by defining POLL_TIMEOUT_EN.
module mul_bus_master #(
  parameter int READ_LATENCY    = 1,
  parameter int STATUS_DONE_BIT = 0,
  parameter int POLL_GAP        = 2,
  parameter int MAX_POLLS       = 1000
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iStart,
  input  logic [31:0] iOpA,
  input  logic [31:0] iOpB,
  input  logic [31:0] iOpC,
  input  logic [31:0] iOpD,
  input  logic [3:0]  iCtrl,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oResult,
  output logic [1:0]  oStatus,
  output logic        oTimeout,
  output logic        oChipSelect_n,
  output logic        oWrite_n,
  output logic        oRead_n,
  output logic [3:0]  oAddress,
  output logic [31:0] oWrData,
  input  logic [31:0] iRdData
);

  localparam logic [3:0] ADDR_RESULT = 4'd5;
  localparam logic [3:0] ADDR_STATUS = 4'd6;

  // One counter serves both the read-latency wait and the inter-poll gap.
  localparam int CNT_MAX = (READ_LATENCY > POLL_GAP) ? READ_LATENCY : POLL_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_POLL, S_PWAIT, S_GAP, S_RREQ, S_RWAIT, S_DONE
  } stateType;

  stateType         state, stateNext;
  logic [2:0]       idx, idxNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [31:0]      opA, opB, opC, opD;
  logic [3:0]       ctrl;
  logic             accept, statusTake, resultTake, pollLimit, timeoutHit;
  logic             csNext, wrNext, rdNext;
  logic [3:0]       addrNext;
  logic [31:0]      dataNext;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    stateNext  = state;
    idxNext    = idx;
    cntNext    = cnt;
    accept     = 1'b0;
    statusTake = 1'b0;
    resultTake = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (iStart) begin
          accept    = 1'b1;
          idxNext   = 3'd0;
          stateNext = S_WRITE;
        end
      end
      S_WRITE: begin
        if (idx == 3'd4) stateNext = S_POLL;
        else             idxNext   = idx + 3'd1;
      end
      S_POLL: begin
        cntNext   = '0;
        stateNext = S_PWAIT;
      end
      S_PWAIT: begin
        if (cnt == WAIT_LAST) begin
          statusTake = 1'b1;
          cntNext    = '0;
          if (iRdData[STATUS_DONE_BIT]) stateNext = S_RREQ;
          else if (pollLimit)           stateNext = S_DONE;
          else if (POLL_GAP == 0)       stateNext = S_POLL;
          else                          stateNext = S_GAP;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) stateNext = S_POLL;
        else                 cntNext   = cnt + CNT_W'(1);
      end
      S_RREQ: begin
        cntNext   = '0;
        stateNext = S_RWAIT;
      end
      S_RWAIT: begin
        if (cnt == WAIT_LAST) begin
          resultTake = 1'b1;
          stateNext  = S_DONE;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  assign timeoutHit = statusTake && !iRdData[STATUS_DONE_BIT] && pollLimit;

  // Bus outputs are registered from the next state, so a strobe is visible exactly while its state is current.
  always_comb begin
    csNext   = 1'b1;
    wrNext   = 1'b1;
    rdNext   = 1'b1;
    addrNext = oAddress;
    dataNext = oWrData;
    unique case (stateNext)
      S_WRITE: begin
        csNext   = 1'b0;
        wrNext   = 1'b0;
        addrNext = {1'b0, idxNext};
        unique case (idxNext)
          3'd0:    dataNext = accept ? iOpA : opA;
          3'd1:    dataNext = opB;
          3'd2:    dataNext = opC;
          3'd3:    dataNext = opD;
          default: dataNext = {28'b0, ctrl};
        endcase
      end
      S_POLL: begin
        csNext   = 1'b0;
        rdNext   = 1'b0;
        addrNext = ADDR_STATUS;
      end
      S_RREQ: begin
        csNext   = 1'b0;
        rdNext   = 1'b0;
        addrNext = ADDR_RESULT;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state         <= S_IDLE;
      idx           <= 3'd0;
      cnt           <= '0;
      opA           <= '0;
      opB           <= '0;
      opC           <= '0;
      opD           <= '0;
      ctrl          <= '0;
      oChipSelect_n <= 1'b1;
      oWrite_n      <= 1'b1;
      oRead_n       <= 1'b1;
      oAddress      <= '0;
      oWrData       <= '0;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
      oResult       <= '0;
      oStatus       <= '0;
    end else begin
      state         <= stateNext;
      idx           <= idxNext;
      cnt           <= cntNext;
      oChipSelect_n <= csNext;
      oWrite_n      <= wrNext;
      oRead_n       <= rdNext;
      oAddress      <= addrNext;
      oWrData       <= dataNext;
      oBusy         <= (stateNext != S_IDLE);
      oDone         <= (stateNext == S_DONE);
      if (accept) begin
        opA  <= iOpA;
        opB  <= iOpB;
        opC  <= iOpC;
        opD  <= iOpD;
        ctrl <= iCtrl;
      end
      if (statusTake) oStatus <= iRdData[1:0];
      if (resultTake)      oResult <= iRdData;
      else if (timeoutHit) oResult <= '0;
    end
  end

`ifdef POLL_TIMEOUT_EN
  localparam int PCNT_W = $clog2(MAX_POLLS + 1);
  logic [PCNT_W-1:0] pollCnt;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      pollCnt  <= '0;
      oTimeout <= 1'b0;
    end else if (accept) begin
      pollCnt  <= '0;
      oTimeout <= 1'b0;
    end else begin
      if (statusTake) pollCnt  <= pollCnt + PCNT_W'(1);
      if (timeoutHit) oTimeout <= 1'b1;
    end
  end

  // The read being sampled now is the MAX_POLLS-th when the counter still shows MAX_POLLS-1.
  assign pollLimit = (pollCnt == PCNT_W'(MAX_POLLS - 1));
`else
  assign pollLimit = 1'b0;
  assign oTimeout  = 1'b0;
`endif

endmodule

// File: tb/tb_mul_bus_master.sv
// Bench for mul_bus_master: behavioural slave, bus transfer log and a cycle-level reference of the expected sequence.
`timescale 1ns/1ps
module tb_mul_bus_master;

  localparam int RL       = 1;
  localparam int GAP      = 2;
  localparam int DONE_BIT = 0;
`ifdef POLL_TIMEOUT_EN
  localparam int MAXP = 4;
`else
  localparam int MAXP = 1000;
`endif
  localparam int PSTEP = GAP + RL + 1;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iStart = 1'b0;
  logic [31:0] iOpA = '0, iOpB = '0, iOpC = '0, iOpD = '0;
  logic [3:0]  iCtrl = '0;
  logic [31:0] iRdData = '0;
  logic        oBusy, oDone, oTimeout, oChipSelect_n, oWrite_n, oRead_n;
  logic [31:0] oResult, oWrData;
  logic [1:0]  oStatus;
  logic [3:0]  oAddress;

  mul_bus_master #(
    .READ_LATENCY(RL), .STATUS_DONE_BIT(DONE_BIT), .POLL_GAP(GAP), .MAX_POLLS(MAXP)
  ) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iStart(iStart),
    .iOpA(iOpA), .iOpB(iOpB), .iOpC(iOpC), .iOpD(iOpD), .iCtrl(iCtrl),
    .oBusy(oBusy), .oDone(oDone), .oResult(oResult), .oStatus(oStatus), .oTimeout(oTimeout),
    .oChipSelect_n(oChipSelect_n), .oWrite_n(oWrite_n), .oRead_n(oRead_n),
    .oAddress(oAddress), .oWrData(oWrData), .iRdData(iRdData)
  );

  always #5 iClk = ~iClk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge iClk) cyc++;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       busLog[$];
  logic [31:0] statusQ[$];
  logic [31:0] regs [0:15];
  int          rdCnt = 0;
  logic [31:0] rdVal = '0;
  bit          prevRd = 1'b0;
  bit          prevWr = 1'b0;
  logic [3:0]  prevWrAddr = '0;

  function automatic logic [31:0] opResult(input logic [31:0] a, b, c, d, input logic [3:0] ctrl);
    if (ctrl == 4'h1) return a * b * c * d;
    return a + b + c + d;
  endfunction

  // Behavioural slave plus protocol monitor, evaluated mid-cycle on stable bus values.
  always @(negedge iClk) begin
    if (rdCnt > 0) begin
      rdCnt--;
      iRdData = (rdCnt == 0) ? rdVal : $urandom;
    end else begin
      iRdData = $urandom;
    end
    if (!oChipSelect_n || !oWrite_n || !oRead_n) begin
      check("cs_matches_strobe", 32'({oChipSelect_n, oWrite_n & oRead_n}), 32'(0));
      check("wr_rd_exclusive", 32'(!oWrite_n && !oRead_n), 32'(0));
      if (!oRead_n) check("rd_one_cycle", 32'(prevRd), 32'(0));
      if (!oWrite_n && prevWr) check("wr_addr_advances", 32'(oAddress == prevWrAddr), 32'(0));
    end
    if (!oChipSelect_n && !oWrite_n) begin
      busLog.push_back('{cyc, 1'b1, oAddress, oWrData});
      regs[oAddress] = oWrData;
    end
    if (!oChipSelect_n && !oRead_n) begin
      busLog.push_back('{cyc, 1'b0, oAddress, 32'h0});
      rdCnt = RL;
      if (oAddress == 4'd6) begin
        if (statusQ.size() > 0) rdVal = statusQ.pop_front();
        else                    rdVal = 32'h0;
      end else if (oAddress == 4'd5) begin
        rdVal = opResult(regs[0], regs[1], regs[2], regs[3], regs[4][3:0]);
      end else begin
        rdVal = $urandom;
      end
    end
    prevRd     = !oRead_n;
    prevWr     = !oWrite_n;
    prevWrAddr = oAddress;
  end

  function automatic logic [31:0] notDone();
    return $urandom & ~(32'h1 << DONE_BIT);
  endfunction

  function automatic logic [31:0] isDone();
    return $urandom | (32'h1 << DONE_BIT);
  endfunction

  // One full operation: drive, wait for oDone, then compare against the expected transfer sequence.
  task automatic runOp(input string tag, input logic [31:0] a, b, c, d, input logic [3:0] ctrl,
                       input bit perturb);
    logic [31:0] stat[$];
    xfer_t       expLog[$];
    int          e, firstDone, nPoll, lastPoll, expDoneCyc, doneCyc, nCmp;
    bit          got, expTimeout;
    logic [1:0]  firstStatus;
    logic [31:0] expResult;

    stat = statusQ;
    busLog.delete();
    @(negedge iClk);
    iOpA = a; iOpB = b; iOpC = c; iOpD = d; iCtrl = ctrl;
    iStart = 1'b1;
    e = cyc + 1;
    @(negedge iClk);
    iStart = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(oBusy), 32'(1));
    if (perturb) begin
      iOpA = $urandom; iOpB = $urandom; iOpC = $urandom; iOpD = $urandom; iCtrl = 4'($urandom);
      repeat (5) @(negedge iClk);
      iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
    end

    got = 1'b0;
    firstStatus = 2'bxx;
    for (int k = 0; k < 3000 && !got; k++) begin
      if (cyc == e + 5 + RL + 1) firstStatus = oStatus;
      if (oDone === 1'b1) got = 1'b1;
      else @(negedge iClk);
    end
    if (!got) begin
      check({tag, "_done_seen"}, 32'(0), 32'(1));
      statusQ.delete();
      return;
    end
    doneCyc = cyc;

    firstDone = -1;
    foreach (stat[i]) if (firstDone < 0 && stat[i][DONE_BIT]) firstDone = i;
`ifdef POLL_TIMEOUT_EN
    expTimeout = (firstDone < 0) || (firstDone >= MAXP);
`else
    expTimeout = 1'b0;
`endif
    nPoll = expTimeout ? MAXP : firstDone + 1;
    for (int i = 0; i < 5; i++)
      expLog.push_back('{e + i, 1'b1, 4'(i), (i == 0) ? a : (i == 1) ? b : (i == 2) ? c : (i == 3) ? d : {28'h0, ctrl}});
    for (int k = 0; k < nPoll; k++) expLog.push_back('{e + 5 + k * PSTEP, 1'b0, 4'd6, 32'h0});
    lastPoll = e + 5 + (nPoll - 1) * PSTEP;
    if (expTimeout) begin
      expDoneCyc = lastPoll + RL + 1;
      expResult  = 32'h0;
    end else begin
      expLog.push_back('{lastPoll + RL + 1, 1'b0, 4'd5, 32'h0});
      expDoneCyc = lastPoll + 2 * RL + 2;
      expResult  = opResult(a, b, c, d, ctrl);
    end

    check({tag, "_done_cycle"}, 32'(doneCyc - e), 32'(expDoneCyc - e));
    check({tag, "_result"}, oResult, expResult);
    check({tag, "_status_last"}, 32'(oStatus), 32'((nPoll - 1 < stat.size()) ? stat[nPoll - 1][1:0] : 2'b00));
    check({tag, "_status_first"}, 32'(firstStatus), 32'((stat.size() > 0) ? stat[0][1:0] : 2'b00));
    check({tag, "_timeout"}, 32'(oTimeout), 32'(expTimeout));
    check({tag, "_busy_in_done"}, 32'(oBusy), 32'(1));
    check({tag, "_xfer_count"}, 32'(busLog.size()), 32'(expLog.size()));
    nCmp = (busLog.size() < expLog.size()) ? busLog.size() : expLog.size();
    for (int i = 0; i < nCmp; i++) begin
      check($sformatf("%s_x%0d_cyc", tag, i), 32'(busLog[i].cyc - e), 32'(expLog[i].cyc - e));
      check($sformatf("%s_x%0d_kind", tag, i), 32'({busLog[i].wr, busLog[i].addr}),
            32'({expLog[i].wr, expLog[i].addr}));
      if (expLog[i].wr) check($sformatf("%s_x%0d_data", tag, i), busLog[i].data, expLog[i].data);
    end
    @(negedge iClk);
    check({tag, "_done_one_cycle"}, 32'(oDone), 32'(0));
    check({tag, "_busy_released"}, 32'(oBusy), 32'(0));
    statusQ.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, rc, rd;
    int          n;
    bit          seen;

    repeat (3) @(negedge iClk);
    check("rst_cs_n", 32'(oChipSelect_n), 32'(1));
    check("rst_wr_n", 32'(oWrite_n), 32'(1));
    check("rst_rd_n", 32'(oRead_n), 32'(1));
    check("rst_addr", 32'(oAddress), 32'(0));
    check("rst_wdata", oWrData, 32'(0));
    check("rst_busy_done_to", 32'({oBusy, oDone, oTimeout}), 32'(0));
    check("rst_result", oResult, 32'(0));
    check("rst_status", 32'(oStatus), 32'(0));
    iReset_n = 1'b1;
    @(negedge iClk);

    // Done on the first poll; slave product of 3,4,5,6 is 0x168.
    statusQ.push_back(32'h0000_0001);
    runOp("t1", 32'd3, 32'd4, 32'd5, 32'd6, 4'h1, 1'b0);
    check("t1_result_literal", oResult, 32'h0000_0168);

    // Done after the third poll.
    statusQ.push_back(notDone()); statusQ.push_back(notDone()); statusQ.push_back(isDone());
    runOp("t2", $urandom, $urandom, $urandom, $urandom, 4'h1, 1'b0);

    // iStart pulsed during POLL and operands changed after accept.
    statusQ.push_back(notDone()); statusQ.push_back(isDone());
    runOp("t3", $urandom, $urandom, $urandom, $urandom, 4'h1, 1'b1);

    // Stale upper STATUS bits are ignored.
    statusQ.push_back(32'hFFFF_FFFC); statusQ.push_back(32'hFFFF_FFFD);
    runOp("t4", $urandom, $urandom, $urandom, $urandom, 4'h2, 1'b0);
    check("t4_status_literal", 32'(oStatus), 32'(2'b01));

    // Random operands, control word and poll counts.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) statusQ.push_back(notDone());
      statusQ.push_back(isDone());
      runOp($sformatf("rnd%0d", r), $urandom, $urandom, $urandom, $urandom,
            ($urandom_range(0, 1) == 1) ? 4'h1 : 4'($urandom), 1'b0);
    end

`ifdef POLL_TIMEOUT_EN
    // Slave never reports done: poll limit ends the operation without a RESULT read.
    for (int k = 0; k < 6; k++) statusQ.push_back(notDone());
    runOp("t5", $urandom, $urandom, $urandom, $urandom, 4'h1, 1'b0);
    check("t5_timeout_literal", 32'(oTimeout), 32'(1));
`else
    // Long polling never raises a timeout when the limit is not built.
    for (int k = 0; k < 6; k++) statusQ.push_back(notDone());
    statusQ.push_back(isDone());
    runOp("t5", $urandom, $urandom, $urandom, $urandom, 4'h1, 1'b0);
`endif

    // Reset asserted in the middle of a poll strobe, then a clean full run.
    for (int k = 0; k < 4; k++) statusQ.push_back(notDone());
    @(negedge iClk);
    ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
    iOpA = ra; iOpB = rb; iOpC = rc; iOpD = rd; iCtrl = 4'h1;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (oRead_n === 1'b0) seen = 1'b1;
      else @(negedge iClk);
    end
    check("t6_read_strobe_seen", 32'(seen), 32'(1));
    #1 iReset_n = 1'b0;
    #1;
    check("t6_async_strobes", 32'({oChipSelect_n, oWrite_n, oRead_n}), 32'(3'b111));
    check("t6_async_busy", 32'(oBusy), 32'(0));
    check("t6_async_done", 32'(oDone), 32'(0));
    @(negedge iClk);
    iReset_n = 1'b1;
    statusQ.delete();
    @(negedge iClk);
    statusQ.push_back(notDone()); statusQ.push_back(isDone());
    runOp("t6", $urandom, $urandom, $urandom, $urandom, 4'h1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
